// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter that time-shares one unsigned magnitude comparator
// among N_REQ requesters; results come back registered with a done pulse and requester ID.
module cmp_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   done,
  output logic [ID_W-1:0]        done_id,
  output logic                   eq,
  output logic                   lt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int IDX_W = ID_W + 1;
  localparam logic [IDX_W-1:0] NREQ_C = IDX_W'(N_REQ);

  state_t            state_r, state_s;
  logic [N_REQ-1:0]  gnt_r, gnt_s;
  logic              done_r, done_s;
  logic [ID_W-1:0]   done_id_r, done_id_s;
  logic              eq_r, eq_s;
  logic              lt_r, lt_s;
  logic [WIDTH-1:0]  a_r, a_s;
  logic [WIDTH-1:0]  b_r, b_s;
  logic [ID_W-1:0]   cur_id_r, cur_id_s;
  logic [ID_W-1:0]   ptr_r, ptr_s;

  logic              found_s;
  logic [ID_W-1:0]   win_s;
  logic [IDX_W-1:0]  idx_s;
  logic [IDX_W-1:0]  nxt_s;
  logic              cmp_eq_s;
  logic              cmp_lt_s;

  // Shared comparator works only on the latched operands, never on a_in/b_in.
  assign cmp_eq_s = (a_r == b_r);
  assign cmp_lt_s = (a_r <  b_r);

  // Round-robin search: first requester at or after ptr_r, wrapping modulo N_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = {1'b0, ptr_r} + IDX_W'(i);
      if (idx_s >= NREQ_C) begin
        idx_s = idx_s - NREQ_C;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[ID_W-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[ID_W-1:0];
      end else begin
        found_s = found_s;
      end
    end
    nxt_s = {1'b0, win_s} + {{ID_W{1'b0}}, 1'b1};
    if (nxt_s >= NREQ_C) begin
      nxt_s = '0;
    end else begin
      nxt_s = nxt_s;
    end
  end

  // Next-state and next-output logic for the IDLE -> EVAL -> RESP cycle.
  always_comb begin
    state_s   = state_r;
    gnt_s     = '0;
    done_s    = 1'b0;
    done_id_s = done_id_r;
    eq_s      = eq_r;
    lt_s      = lt_r;
    a_s       = a_r;
    b_s       = b_r;
    cur_id_s  = cur_id_r;
    ptr_s     = ptr_r;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          gnt_s    = {{(N_REQ-1){1'b0}}, 1'b1} << win_s;
          a_s      = a_in[int'(win_s)*WIDTH +: WIDTH];
          b_s      = b_in[int'(win_s)*WIDTH +: WIDTH];
          cur_id_s = win_s;
          ptr_s    = nxt_s[ID_W-1:0];
          state_s  = EVAL;
        end else begin
          state_s  = IDLE;
        end
      end
      EVAL: begin
        eq_s      = cmp_eq_s;
        lt_s      = cmp_lt_s;
        done_s    = 1'b1;
        done_id_s = cur_id_r;
        state_s   = RESP;
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers; async reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      gnt_r     <= '0;
      done_r    <= 1'b0;
      done_id_r <= '0;
      eq_r      <= 1'b0;
      lt_r      <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      cur_id_r  <= '0;
      ptr_r     <= '0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      done_r    <= done_s;
      done_id_r <= done_id_s;
      eq_r      <= eq_s;
      lt_r      <= lt_s;
      a_r       <= a_s;
      b_r       <= b_s;
      cur_id_r  <= cur_id_s;
      ptr_r     <= ptr_s;
    end
  end

  assign gnt     = gnt_r;
  assign done    = done_r;
  assign done_id = done_id_r;
  assign eq      = eq_r;
  assign lt      = lt_r;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: vector table plus hand-written corner
// sequences; expected results are queued at drive time and popped when done fires.
module tb_cmp_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  gnt;
  logic        done;
  logic [1:0]  done_id;
  logic        eq;
  logic        lt;

  int total = 0;
  int bad   = 0;

  logic [3:0] sb[$];

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    logic        eq;
    logic        lt;
  } vec_t;

  vec_t vecs[11];

  cmp_share_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .a_in    (a_in),
    .b_in    (b_in),
    .gnt     (gnt),
    .done    (done),
    .done_id (done_id),
    .eq      (eq),
    .lt      (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done_id=%0d with nothing outstanding at %0t", done_id, $time);
      end else begin
        logic [3:0] e;
        e = sb.pop_front();
        chk("done_id", {30'd0, done_id}, {30'd0, e[3:2]});
        chk("eq", {31'd0, eq}, {31'd0, e[1]});
        chk("lt", {31'd0, lt}, {31'd0, e[0]});
      end
    end
  end

  task automatic run_txn(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] a_post, input logic [31:0] b_post,
                         input int id, input logic e, input logic l);
    logic [1:0] id2;
    id2 = 2'(id);
    @(negedge clk);
    req  = r;
    a_in = a;
    b_in = b;
    sb.push_back({id2, e, l});
    @(posedge clk); #1;
    chk("gnt", {28'd0, gnt}, {28'd0, 4'b0001 << id2});
    @(negedge clk);
    req  = 4'b0000;
    a_in = a_post;
    b_in = b_post;
    @(posedge clk); #1;
    chk("done_hi", {31'd0, done}, 32'd1);
    chk("gnt_eval", {28'd0, gnt}, 32'd0);
    @(posedge clk); #1;
    chk("done_lo", {31'd0, done}, 32'd0);
    chk("gnt_resp", {28'd0, gnt}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 32'h0000_0000, 32'h0000_0080, 0, 1'b0, 1'b1};
    vecs[1]  = '{4'b0100, 32'h00A5_0000, 32'h00A5_0000, 2, 1'b1, 1'b0};
    vecs[2]  = '{4'b0100, 32'h00FF_0000, 32'h007F_0000, 2, 1'b0, 1'b0};
    vecs[3]  = '{4'b1000, 32'h0100_0000, 32'h0100_0000, 3, 1'b1, 1'b0};
    vecs[4]  = '{4'b1111, 32'h7F90_3310, 32'h800F_3320, 0, 1'b0, 1'b1};
    vecs[5]  = '{4'b1111, 32'h7F90_3310, 32'h800F_3320, 1, 1'b1, 1'b0};
    vecs[6]  = '{4'b1111, 32'h7F90_3310, 32'h800F_3320, 2, 1'b0, 1'b0};
    vecs[7]  = '{4'b1111, 32'h7F90_3310, 32'h800F_3320, 3, 1'b0, 1'b1};
    vecs[8]  = '{4'b1111, 32'h7F90_3310, 32'h800F_3320, 0, 1'b0, 1'b1};
    vecs[9]  = '{4'b0010, 32'h0000_FF00, 32'h0000_FF00, 1, 1'b1, 1'b0};
    vecs[10] = '{4'b0011, 32'h0000_007F, 32'h0000_00FF, 0, 1'b0, 1'b1};

    rst_n = 1'b0;
    req   = 4'b0000;
    a_in  = 32'd0;
    b_in  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", {28'd0, gnt}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_done_id", {30'd0, done_id}, 32'd0);
    chk("rst_eq", {31'd0, eq}, 32'd0);
    chk("rst_lt", {31'd0, lt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_gnt", {28'd0, gnt}, 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].a, vecs[i].b,
              vecs[i].id, vecs[i].eq, vecs[i].lt);
    end

    // Operand A of requester 1 changes after the grant; the latched 0x10 must be used.
    run_txn(4'b0010, 32'h0000_1000, 32'h0000_2000, 32'h0000_F000, 32'h0000_2000, 1, 1'b0, 1'b1);

    // Reset during EVAL: no done may follow and the pointer must restart at 0.
    @(negedge clk);
    req  = 4'b0010;
    a_in = 32'h0000_4400;
    b_in = 32'h0000_4400;
    @(posedge clk); #1;
    chk("pre_rst_gnt", {28'd0, gnt}, 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", {28'd0, gnt}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_eq", {31'd0, eq}, 32'd0);
    chk("mid_rst_lt", {31'd0, lt}, 32'd0);
    @(negedge clk);
    req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_done", {31'd0, done}, 32'd0);
    end
    run_txn(4'b1010, 32'h0000_0500, 32'hFF00_0300, 32'h0000_0500, 32'hFF00_0300, 1, 1'b0, 1'b0);
    run_txn(4'b1000, 32'h0000_0500, 32'hFF00_0300, 32'h0000_0500, 32'hFF00_0300, 3, 1'b0, 1'b1);

    // One-cycle req0 pulse while serving requester 1 in RESP must be ignored.
    @(negedge clk);
    req  = 4'b0010;
    a_in = 32'h0000_2000;
    b_in = 32'h0000_2000;
    sb.push_back({2'd1, 1'b1, 1'b0});
    @(posedge clk); #1;
    chk("pulse_gnt", {28'd0, gnt}, 32'h2);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk); #1;
    chk("pulse_done_hi", {31'd0, done}, 32'd1);
    @(negedge clk);
    req = 4'b0001;
    @(posedge clk); #1;
    chk("pulse_done_lo", {31'd0, done}, 32'd0);
    @(negedge clk);
    req = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("pulse_no_gnt", {28'd0, gnt}, 32'd0);
      chk("pulse_no_done", {31'd0, done}, 32'd0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
